mem_block_mover: RTL and testbench
==================================

Name: mem_block_mover

Overview:
- Sequencer directly upstream of the image data memory (64-bit words, 16-bit word address, combinational read, level-sensitive write, save/doneSaving flush handshake).
- Copies a run of L consecutive words from a source base to a destination base, overlap-safe (memmove semantics).
- Optionally requests a memory flush to the image file when the copy finishes.
- Used by the image-processing control path to move tiles/rows without the processor core.

Parameters:
- ADDR_W, 16, word address width.
- DATA_W, 64, word width.
- MEM_DEPTH, 15451, number of valid words; legal addresses are 0..MEM_DEPTH-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- src_base  in  ADDR_W  first source word; sampled with start.
- dst_base  in  ADDR_W  first destination word; sampled with start.
- length  in  ADDR_W  word count L; sampled with start.
- save_req  in  1  flush after copy; sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- error  out  1  valid only while done=1; 1 means a range violation and no writes were made.
- mem_address  out  ADDR_W  to memory address; registered.
- mem_wdata  out  DATA_W  to memory inputData; registered.
- mem_we  out  1  to memory writeEnable; registered.
- mem_save  out  1  to memory save; registered.
- mem_rdata  in  DATA_W  from memory out (combinational read).
- mem_done_saving  in  1  from memory doneSaving; level, sticky.

Behaviour:
- Reset: state IDLE; busy, done, error, mem_we, mem_save = 0; mem_address, mem_wdata = 0; internal counters = 0. Reset asserted mid-copy aborts immediately; no further writes occur. Words already written stay written.
- IDLE: when start=1, latch the command and go to CHECK. Start while not in IDLE is ignored.
- CHECK (1 cycle):
  - If L=0, go to DONE with error=0.
  - Otherwise compute, in 17-bit arithmetic, src_base+L-1 and dst_base+L-1. If either exceeds MEM_DEPTH-1, go to DONE with error=1.
  - Set dir=descending when dst_base>src_base and dst_base<=src_base+L-1; otherwise dir=ascending.
  - Set index i to 0 for ascending or L-1 for descending, then go to RD.
- RD: mem_address=src_base+i, mem_we=0. At the end of the cycle, capture mem_rdata into the data register. Go to WS.
- WS: mem_address=dst_base+i, mem_wdata=captured word, mem_we=0 (address/data setup). Go to WR.
- WR: mem_we=1; address and data held. Then:
  - If this is the last word (i=L-1 ascending, i=0 descending): go to SAVE if save_req was latched, else DONE.
  - Otherwise step i by ±1 and go to RD.
- Invariant: mem_address and mem_wdata never change in a cycle where mem_we=1. mem_we is high only in WR.
- Throughput: 3 cycles per word.
- SAVE: mem_save=1 is held until mem_done_saving=1 is sampled, then mem_save=0 and go to DONE. Because mem_done_saving is sticky, a second save completes one cycle after entry.
- DONE (1 cycle): done=1, error as decided, busy=0 on the next cycle. Return to IDLE.
- Latency, measured in edges after the start-sampling edge:
  - L≥1, no save: done high at edge 3L+2.
  - L=0 or range error: done high at edge 2.
- busy is high in CHECK, RD, WS, WR, SAVE and DONE.

Optional Feature:
- Macro: MEM_BLOCK_MOVER_CHECKSUM_EN.
- Defined:
  - Adds output checksum (DATA_W).
  - Cleared to 0 in CHECK.
  - XOR-accumulates each word captured in RD.
  - Stable from DONE until the next accepted start.
  - Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic copy: preload words 100..103 = 0xA0..0xA3; start src=100, dst=200, L=4, save_req=0. Required: words 200..203 = 0xA0..0xA3; done at edge 14; error=0; 4 write pulses, each with a stable address.
- Overlap: preload 10..14 = 1..5; src=10, dst=12, L=5. Required: words 12..16 = 1,2,3,4,5, written descending (first write to 16); 10..11 unchanged.
- Range and zero length:
  - src=15448, L=4: done+error=1 at edge 2, zero writes.
  - L=0: done at edge 2, error=0, zero writes.
  - dst=15447, L=4 (last address 15450): accepted.
- Save handshake: L=1, save_req=1, model doneSaving rising 5 cycles after save. Required: mem_save held 5 cycles then drops; done one cycle later.
- Reset and ignored start: assert rst_n=0 during the 3rd word of a 6-word copy. Required: all outputs 0 immediately; words 3..5 are not written. Separately, a start pulsed while busy is ignored.
- Checksum (macro defined): copy words 0x0F, 0xF0, 0xFF. Required: checksum = 0x00.

Source files
------------

// File: rtl/mem_block_mover.sv
// mem_block_mover: overlap-safe (memmove) block copy sequencer placed in front
// of the image data memory. A word copy is read, address/data setup, then a
// one-cycle write strobe, giving three cycles per word.
// All outputs are registered from the current state, so the memory interface
// shows each phase one cycle after the FSM enters it.
// Optional feature macro: MEM_BLOCK_MOVER_CHECKSUM_EN adds a running XOR
// checksum output over every word read.
module mem_block_mover #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 64,
    parameter int MEM_DEPTH = 15451
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W-1:0] length,
    input  logic              save_req,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_save,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done_saving
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RD,
        S_WS,
        S_WR,
        S_SAVE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(MEM_DEPTH - 1);

    state_t state, state_next;

    logic [ADDR_W-1:0] src_reg;
    logic [ADDR_W-1:0] dst_reg;
    logic [ADDR_W-1:0] len_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic              save_flag_reg;
    logic              desc_reg;
    logic              err_reg;

    // Last touched addresses are computed one bit wider so a run that wraps
    // past the top of the address space is still caught as out of range.
    logic [ADDR_W:0] src_last;
    logic [ADDR_W:0] dst_last;
    logic            range_bad;
    logic            overlap_desc;
    logic            last_word;

    assign src_last     = {1'b0, src_reg} + {1'b0, len_reg} - (ADDR_W + 1)'(1);
    assign dst_last     = {1'b0, dst_reg} + {1'b0, len_reg} - (ADDR_W + 1)'(1);
    assign range_bad    = (src_last > LAST_ADDR) || (dst_last > LAST_ADDR);
    // Destination starting inside the source run must be copied top-down so
    // no source word is overwritten before it has been read.
    assign overlap_desc = (dst_reg > src_reg) && ({1'b0, dst_reg} <= src_last);
    assign last_word    = desc_reg ? (idx_reg == '0)
                                   : (idx_reg == len_reg - ADDR_W'(1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (len_reg == '0 || range_bad) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_RD;
                end
            end
            S_RD:    state_next = S_WS;
            S_WS:    state_next = S_WR;
            S_WR: begin
                if (!last_word) begin
                    state_next = S_RD;
                end else if (save_flag_reg) begin
                    state_next = S_SAVE;
                end else begin
                    state_next = S_DONE;
                end
            end
            S_SAVE: begin
                if (mem_done_saving) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Command latch, range/direction decision and word index stepping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_reg       <= '0;
            dst_reg       <= '0;
            len_reg       <= '0;
            idx_reg       <= '0;
            save_flag_reg <= 1'b0;
            desc_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_reg       <= src_base;
                        dst_reg       <= dst_base;
                        len_reg       <= length;
                        save_flag_reg <= save_req;
                    end
                end
                S_CHECK: begin
                    err_reg  <= (len_reg != '0) && range_bad;
                    desc_reg <= overlap_desc;
                    idx_reg  <= overlap_desc ? (len_reg - ADDR_W'(1)) : '0;
                end
                S_WR: begin
                    if (!last_word) begin
                        idx_reg <= desc_reg ? (idx_reg - ADDR_W'(1))
                                            : (idx_reg + ADDR_W'(1));
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered status and memory-side outputs. The read address set up for
    // RD is visible during WS, so the word returned then is the source word;
    // it is captured straight into the write-data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            mem_we      <= 1'b0;
            mem_save    <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            busy     <= (state != S_IDLE);
            done     <= (state == S_DONE);
            error    <= (state == S_DONE) && err_reg;
            mem_we   <= (state == S_WR);
            mem_save <= (state == S_SAVE) && !mem_done_saving;
            case (state)
                S_RD: mem_address <= src_reg + idx_reg;
                S_WS: begin
                    mem_address <= dst_reg + idx_reg;
                    mem_wdata   <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
    // Running XOR of every source word, restarted for each accepted command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (state == S_CHECK) begin
            checksum <= '0;
        end else if (state == S_WS) begin
            checksum <= checksum ^ mem_rdata;
        end
    end
`endif

endmodule

// File: tb/tb_mem_block_mover.sv
// Testbench for mem_block_mover: directed cases followed by randomized copies,
// each checked against a memmove reference of the whole memory image.
module tb_mem_block_mover;

    localparam int DEPTH = 15451;
    localparam int LAST  = DEPTH - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] src_base, dst_base, length;
    logic        save_req;
    logic        busy, done, error;
    logic [15:0] mem_address;
    logic [63:0] mem_wdata;
    logic        mem_we, mem_save;
    logic [63:0] mem_rdata;
    logic        mem_done_saving;
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
    logic [63:0] checksum;
`endif

    mem_block_mover dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .src_base        (src_base),
        .dst_base        (dst_base),
        .length          (length),
        .save_req        (save_req),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_we          (mem_we),
        .mem_save        (mem_save),
        .mem_rdata       (mem_rdata),
        .mem_done_saving (mem_done_saving)
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
        ,
        .checksum        (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Memory model, write log and cycle counter
    bit [63:0] tb_mem  [0:DEPTH-1];
    bit [63:0] ref_mem [0:DEPTH-1];
    logic [15:0] wr_log [0:4095];
    int wr_count = 0;
    int stable_bad = 0;
    int cyc = 0;
    logic [15:0] prev_addr = '0;
    logic [63:0] prev_data = '0;
    logic        pl_we = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [63:0] pl_data = '0;

    assign mem_rdata = tb_mem[mem_address];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (pl_we) begin
            tb_mem[pl_addr] <= pl_data;
        end else if (mem_we) begin
            tb_mem[mem_address] <= mem_wdata;
            if (wr_count < 4096) wr_log[wr_count] <= mem_address;
            wr_count <= wr_count + 1;
            if (mem_address !== prev_addr || mem_wdata !== prev_data)
                stable_bad <= stable_bad + 1;
        end
        prev_addr <= mem_address;
        prev_data <= mem_wdata;
    end

    // Flush model: doneSaving rises during the fifth cycle of save and sticks
    logic ds_clear = 1'b0;
    int   save_seen = 0;
    int   save_cycles = 0;
    always @(posedge clk) begin
        if (ds_clear) begin
            mem_done_saving <= 1'b0;
            save_seen       <= 0;
            save_cycles     <= 0;
        end else begin
            if (mem_save) save_cycles <= save_cycles + 1;
            if (mem_save && !mem_done_saving) begin
                if (save_seen == 3) mem_done_saving <= 1'b1;
                save_seen <= save_seen + 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int a, input logic [63:0] v);
        pl_addr    = 16'(a);
        pl_data    = v;
        pl_we      = 1'b1;
        ref_mem[a] = v;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic mem_compare(input string tag);
        int bad = 0;
        for (int i = 0; i < DEPTH; i++)
            if (tb_mem[i] !== ref_mem[i]) bad++;
        check(tag, 64'(bad), 64'd0);
    endtask

    // One command: reference memmove, then latency/error/write-trace checks
    task automatic run_cmd(input int s, input int d, input int l, input bit sv,
                           input int inj, input int lat_in);
        int wc0, sb0, c0, lat, nw, bad, lat_exp;
        bit err_e, desc_e, got;
        logic [63:0] tmp[$];
        logic [63:0] cks_e;
        err_e  = (l != 0) && ((s + l - 1 > LAST) || (d + l - 1 > LAST));
        desc_e = (d > s) && (d < s + l);
        nw     = (l == 0 || err_e) ? 0 : l;
        cks_e  = '0;
        for (int j = 0; j < nw; j++) begin
            tmp.push_back(ref_mem[s + j]);
            cks_e ^= ref_mem[s + j];
        end
        for (int j = 0; j < nw; j++) ref_mem[d + j] = tmp[j];
        lat_exp = (lat_in > 0) ? lat_in : ((nw == 0) ? 2 : 3 * l + 2);
        wc0 = wr_count;
        sb0 = stable_bad;
        src_base = 16'(s); dst_base = 16'(d); length = 16'(l); save_req = sv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c0  = cyc;
        got = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (inj > 0 && n == inj) begin
                start = 1'b1; src_base = 16'd0; dst_base = 16'd5; length = 16'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        lat = cyc - c0;
        check("done_seen", 64'(got), 64'd1);
        if (!got) return;
        $display("cmd src=%0d dst=%0d len=%0d save=%0d latency=%0d error=%0d", s, d, l, sv, lat, error);
        check("latency", 64'(lat), 64'(lat_exp));
        check("error", 64'(error), 64'(err_e));
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
        check("checksum", checksum, cks_e);
`endif
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd0);
        check("busy_off", 64'(busy), 64'd0);
        check("write_count", 64'(wr_count - wc0), 64'(nw));
        bad = 0;
        for (int j = 0; j < nw; j++)
            if (wr_log[wc0 + j] !== 16'(desc_e ? d + nw - 1 - j : d + j)) bad++;
        check("write_order", 64'(bad), 64'd0);
        check("addr_stable", 64'(stable_bad - sb0), 64'd0);
        mem_compare("mem_image");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc0, n;
        rst_n = 1'b0; start = 1'b0; save_req = 1'b0;
        src_base = '0; dst_base = '0; length = '0;
        ds_clear = 1'b1;
        repeat (3) @(negedge clk);
        ds_clear = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_save", 64'(mem_save), 64'd0);
        check("rst_addr", 64'(mem_address), 64'd0);
        check("rst_wdata", mem_wdata, 64'd0);
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
        check("rst_checksum", checksum, 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Basic copy
        for (int j = 0; j < 4; j++) preload(100 + j, 64'hA0 + 64'(j));
        run_cmd(100, 200, 4, 1'b0, 0, 14);
        check("basic_w203", 64'(tb_mem[203]), 64'hA3);

        // Overlapping copy, destination above source
        for (int j = 0; j < 5; j++) preload(10 + j, 64'(j + 1));
        run_cmd(10, 12, 5, 1'b0, 0, 0);
        check("overlap_w16", 64'(tb_mem[16]), 64'd5);
        check("overlap_w10", 64'(tb_mem[10]), 64'd1);

        // Range errors, zero length, top-of-memory accepted
        run_cmd(15448, 300, 4, 1'b0, 0, 2);
        run_cmd(50, 60, 0, 1'b0, 0, 2);
        run_cmd(100, 15447, 4, 1'b0, 0, 14);

        // Save handshake
        preload(500, 64'h5A5A);
        ds_clear = 1'b1;
        @(negedge clk);
        ds_clear = 1'b0;
        run_cmd(500, 600, 1, 1'b1, 0, 11);
        check("save_cycles", 64'(save_cycles), 64'd5);
        check("save_low", 64'(mem_save), 64'd0);

        // Reset during the third word of a six-word copy
        for (int j = 0; j < 6; j++) begin
            preload(300 + j, 64'h300 + 64'(j));
            preload(400 + j, 64'hDEAD);
        end
        wc0 = wr_count;
        src_base = 16'd300; dst_base = 16'd400; length = 16'd6; save_req = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (n = 0; n < 100; n++) begin
            if (wr_count - wc0 >= 2) break;
            @(negedge clk);
        end
        check("rst_wait", 64'(n < 100), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_we", 64'(mem_we), 64'd0);
        check("abort_addr", 64'(mem_address), 64'd0);
        check("abort_wdata", mem_wdata, 64'd0);
        check("abort_done", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        check("abort_writes", 64'(wr_count - wc0), 64'd2);
        ref_mem[400] = ref_mem[300];
        ref_mem[401] = ref_mem[301];
        mem_compare("abort_image");
        $display("abort test writes=%0d", wr_count - wc0);
        rst_n = 1'b1;
        @(negedge clk);

        // Start pulsed while busy must be ignored
        for (int j = 0; j < 3; j++) preload(700 + j, 64'h7700 + 64'(j));
        preload(0, 64'h1234);
        preload(1, 64'h5678);
        wc0 = wr_count;
        run_cmd(700, 800, 3, 1'b0, 4, 11);
        repeat (4) @(negedge clk);
        check("ignored_writes", 64'(wr_count - wc0), 64'd3);
        check("ignored_busy", 64'(busy), 64'd0);

        // Words whose XOR is zero
        preload(900, 64'h0F);
        preload(901, 64'hF0);
        preload(902, 64'hFF);
        run_cmd(900, 950, 3, 1'b0, 0, 11);
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
        check("checksum_zero", checksum, 64'd0);
`endif

        // Randomized copies in a low window and at the top of memory
        for (int a = 1000; a < 1053; a++) preload(a, {$urandom, $urandom});
        for (int a = 15438; a <= LAST; a++) preload(a, {$urandom, $urandom});
        for (int t = 0; t < 30; t++) begin
            int s, d, l;
            if ($urandom_range(0, 3) == 3) begin
                s = $urandom_range(15438, LAST);
                d = $urandom_range(15438, LAST);
            end else begin
                s = $urandom_range(1000, 1040);
                d = $urandom_range(1000, 1040);
            end
            l = $urandom_range(0, 12);
            run_cmd(s, d, l, 1'b0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
